// File: rtl/fifo_sequencer_pkg.sv
// Shared definitions for the FIFO sequencer: state encoding, pointer width
// helper, default parameters and a parameter legality check.
package fifo_sequencer_pkg;

  localparam int DEF_NUM_REG   = 4;
  localparam int DEF_NUMP1     = 5;
  localparam int DEF_PAR_WRITE = 2;
  localparam int DEF_PAR_READ  = 1;

  typedef enum logic [1:0] {
    ST_INIT  = 2'd0,
    ST_RUN   = 2'd1,
    ST_FLUSH = 2'd2
  } state_t;

  // Width of pointers and occupancy: one extra bit so NUM_REG itself fits.
  function automatic int pw_of(input int num_reg);
    return $clog2(num_reg) + 1;
  endfunction

  // The pointer ring must be one slot larger than the capacity, and a single
  // beat can never move more entries than the FIFO holds.
  function automatic bit params_legal(input int num_reg, input int nump1,
                                      input int par_write, input int par_read);
    return (nump1 == num_reg + 1) && (par_write >= 1) && (par_read >= 1) &&
           (par_write <= num_reg) && (par_read <= num_reg);
  endfunction

endpackage

// File: rtl/fifo_sequencer_if.sv
// Handshake and status bundle between a producer/consumer pair and the
// FIFO sequencer. The master side drives the requests, the slave side is
// the sequencer itself.
interface fifo_sequencer_if
  import fifo_sequencer_pkg::*;
#(
  parameter int PW = pw_of(DEF_NUM_REG)
);

  logic          flush;
  logic          wr_valid;
  logic          wr_ready;
  logic          rd_ready;
  logic          rd_valid;
  logic          wr_en;
  logic          rd_en;
  logic [PW-1:0] wr_ptr;
  logic [PW-1:0] rd_ptr;
  logic [PW-1:0] count;
  logic          full;
  logic          empty;

  modport master (
    output flush, wr_valid, rd_ready,
    input  wr_ready, rd_valid, wr_en, rd_en, wr_ptr, rd_ptr, count, full, empty
  );

  modport slave (
    input  flush, wr_valid, rd_ready,
    output wr_ready, rd_valid, wr_en, rd_en, wr_ptr, rd_ptr, count, full, empty
  );

endinterface

// File: rtl/fifo_sequencer_ring_pointer.sv
// Modular pointer that advances by a fixed step around a ring of MOD slots.
// clear (or rst) forces it back to slot zero and wins over inc.
module ring_pointer #(
  parameter int PW   = 3,
  parameter int STEP = 1,
  parameter int MOD  = 5
) (
  input  logic          clk,
  input  logic          rst,
  input  logic          clear,
  input  logic          inc,
  output logic [PW-1:0] ptr
);

  localparam logic [PW:0] STEP_W = STEP[PW:0];
  localparam logic [PW:0] MOD_W  = MOD[PW:0];

  logic [PW:0]   sum;
  logic [PW-1:0] ptr_next;

  // Wrapped successor, computed one bit wider so ptr+STEP cannot overflow.
  always_comb begin
    sum      = {1'b0, ptr} + STEP_W;
    ptr_next = (sum >= MOD_W) ? PW'(sum - MOD_W) : PW'(sum);
  end

  // Pointer register: reset/clear to zero, otherwise step on inc.
  always_ff @(posedge clk) begin
    if (rst || clear) begin
      ptr <= '0;
    end else if (inc) begin
      ptr <= ptr_next;
    end
  end

endmodule

// File: rtl/fifo_sequencer.sv
// FIFO control sequencer: tracks read/write addresses and occupancy for a
// FIFO whose producer writes PAR_WRITE entries per beat and whose consumer
// reads PAR_READ entries per beat. INIT and FLUSH are one-cycle states that
// leave everything cleared; handshakes are only honoured in RUN.
module fifo_sequencer
  import fifo_sequencer_pkg::*;
#(
  parameter int NUM_REG   = DEF_NUM_REG,
  parameter int NUMP1     = DEF_NUMP1,
  parameter int PAR_WRITE = DEF_PAR_WRITE,
  parameter int PAR_READ  = DEF_PAR_READ
) (
  input  logic              clk,
  input  logic              rst,
  fifo_sequencer_if.slave   bus
);

  localparam int PW = pw_of(NUM_REG);

  localparam logic [PW:0]   WSTEP_W = PAR_WRITE[PW:0];
  localparam logic [PW:0]   RSTEP_W = PAR_READ[PW:0];
  localparam logic [PW:0]   NUM_W   = NUM_REG[PW:0];
  localparam logic [PW-1:0] NUM_P   = NUM_REG[PW-1:0];
  localparam logic [PW-1:0] RSTEP_P = PAR_READ[PW-1:0];

  if (!params_legal(NUM_REG, NUMP1, PAR_WRITE, PAR_READ)) begin : g_illegal
    $error("fifo_sequencer: illegal NUM_REG/NUMP1/PAR_WRITE/PAR_READ combination");
  end

  state_t        state_q;
  state_t        state_d;
  logic          active;
  logic          run_ok;
  logic          wr_ready;
  logic          rd_valid;
  logic          wr_en;
  logic          rd_en;
  logic [PW-1:0] count;

  // State register; reset always lands in INIT.
  always_ff @(posedge clk) begin
    if (rst) begin
      state_q <= ST_INIT;
    end else begin
      state_q <= state_d;
    end
  end

  // Next state and handshake qualification. A flush in RUN blocks the beat
  // in the same cycle and also clears the pointers at that edge, so the
  // FLUSH cycle already shows an empty FIFO.
  always_comb begin
    state_d  = state_q;
    active   = (state_q == ST_RUN) && !rst;
    run_ok   = active && !bus.flush;
    wr_ready = run_ok && (({1'b0, count} + WSTEP_W) <= NUM_W);
    rd_valid = run_ok && (count >= RSTEP_P);
    wr_en    = bus.wr_valid && wr_ready;
    rd_en    = bus.rd_ready && rd_valid;
    case (state_q)
      ST_INIT:  state_d = ST_RUN;
      ST_RUN:   state_d = bus.flush ? ST_FLUSH : ST_RUN;
      ST_FLUSH: state_d = ST_RUN;
      default:  state_d = ST_INIT;
    endcase
  end

  // Occupancy register; both strobes are qualified against the current
  // count, so the one-bit-wider sum never wraps.
  always_ff @(posedge clk) begin
    if (rst || !run_ok) begin
      count <= '0;
    end else begin
      count <= PW'({1'b0, count} + (wr_en ? WSTEP_W : '0) - (rd_en ? RSTEP_W : '0));
    end
  end

  ring_pointer #(
    .PW   (PW),
    .STEP (PAR_WRITE),
    .MOD  (NUMP1)
  ) u_wr_ptr (
    .clk   (clk),
    .rst   (rst),
    .clear (!run_ok),
    .inc   (wr_en),
    .ptr   (bus.wr_ptr)
  );

  ring_pointer #(
    .PW   (PW),
    .STEP (PAR_READ),
    .MOD  (NUMP1)
  ) u_rd_ptr (
    .clk   (clk),
    .rst   (rst),
    .clear (!run_ok),
    .inc   (rd_en),
    .ptr   (bus.rd_ptr)
  );

  assign bus.wr_ready = wr_ready;
  assign bus.rd_valid = rd_valid;
  assign bus.wr_en    = wr_en;
  assign bus.rd_en    = rd_en;
  assign bus.count    = count;
  assign bus.full     = active && (count == NUM_P);
  assign bus.empty    = !active || (count == '0);

endmodule
